song_sequencer: RTL and testbench

// - Plays a stored score by driving the 32-bit `song` keycode word consumed by the I2S tone/wavetable stage.
// - Holds the score in on-chip RAM written by the Nios/Avalon host. Steps entries at a programmable tick rate.
// - Inserts a silent gap between notes so repeated keys retrigger: the I2S stage resets a tone's phase when its key drops.

---
 rtl/song_seq_pkg.sv | 25 ++
 rtl/song_score_ram.sv | 38 +++
 rtl/song_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_song_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_seq_pkg.sv
// Shared types and constants for the song sequencer: FSM state encoding,
// host register offsets, score entry field positions and a tick-period helper.
package song_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TICK   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int DUR_MSB = 31;
    localparam int DUR_LSB = 24;

    // A programmed period of 0 behaves like 1 so the prescaler always ticks.
    function automatic logic [23:0] eff_period(input logic [23:0] period);
        return (period == 24'd0) ? 24'd1 : period;
    endfunction

endpackage

// File: rtl/song_score_ram.sv
// Score storage: DEPTH x 32 simple dual-port RAM with synchronous reads.
// Port A belongs to the host, port B to the sequencer. A port B read of an
// address being written on port A in the same cycle returns the old word.
module song_score_ram
    import song_seq_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] a_addr_i,
    input  logic             a_we_i,
    input  logic             a_re_i,
    input  logic [31:0]      a_wdata_i,
    output logic [31:0]      a_rdata_o,
    input  logic [IDX_W-1:0] b_addr_i,
    output logic [31:0]      b_rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;

    // Read-before-write memory array with a registered read on each port.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (a_re_i) begin
            a_rdata_q <= mem_q[a_addr_i];
        end
        b_rdata_q <= mem_q[b_addr_i];
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/song_sequencer.sv
// Score player: walks the score RAM at a programmable tick rate and drives the
// packed keycode word for the I2S tone stage, inserting silence between notes
// so that a repeated key is seen to drop and retrigger.
module song_sequencer
    import song_seq_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int GAP_TICKS = 1,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W:0]   avs_address,
    input  logic             avs_write,
    input  logic             avs_read,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic [31:0]      song,
    output logic             playing,
    output logic [IDX_W-1:0] note_index,
    output logic             song_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [7:0]       GAP_LEN  = 8'(GAP_TICKS);

    state_t           state_q, state_d;
    logic [1:0]       ctrl_q, ctrl_d;        // {loop, run}
    logic [23:0]      tick_q, tick_d;
    logic [23:0]      presc_q, presc_d;
    logic [7:0]       dur_q, dur_d;          // remaining note or gap ticks
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      song_q, song_d;
    logic             done_q, done_d;
    logic             playing_q;
    logic [31:0]      reg_rd_q, reg_rd_d;
    logic             ram_sel_q;

    logic [31:0]      ram_a_rdata_s, ram_b_rdata_s;
    logic [7:0]       entry_dur_s;
    logic             tick_s, adv_s, stop_s, adv_stop_s;
    logic             reg_wr_s;
    logic [IDX_W-1:0] adv_idx_s;

    assign entry_dur_s = ram_b_rdata_s[DUR_MSB:DUR_LSB];
    assign reg_wr_s    = avs_write & avs_address[IDX_W];
    // Compared against the live period so a mid-note TICK_PERIOD write applies at once.
    assign tick_s      = (presc_q >= (eff_period(tick_q) - 24'd1));
    assign adv_stop_s  = (idx_q == LAST_IDX) & ~ctrl_q[1];
    assign adv_idx_s   = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));

    song_score_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i     (CLK),
        .a_addr_i  (avs_address[IDX_W-1:0]),
        .a_we_i    (avs_write & ~avs_address[IDX_W]),
        .a_re_i    (avs_read & ~avs_address[IDX_W]),
        .a_wdata_i (avs_writedata),
        .a_rdata_o (ram_a_rdata_s),
        .b_addr_i  (idx_q),
        .b_rdata_o (ram_b_rdata_s)
    );

    // Sequencer FSM next state, with host CTRL/TICK writes applied last so they win.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        tick_d  = tick_q;
        presc_d = presc_q;
        dur_d   = dur_q;
        idx_d   = idx_q;
        song_d  = song_q;
        done_d  = 1'b0;
        adv_s   = 1'b0;
        stop_s  = 1'b0;

        case (state_q)
            IDLE: begin
                song_d = 32'h0000_0000;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (entry_dur_s != 8'd0) begin
                    song_d  = {8'h00, ram_b_rdata_s[23:0]};
                    presc_d = 24'd0;
                    dur_d   = entry_dur_s;
                    state_d = PLAY;
                end else if (ctrl_q[1] && (idx_q != {IDX_W{1'b0}})) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = FETCH;
                end else begin
                    // End marker; at index 0 this also stops a looping empty score.
                    stop_s = 1'b1;
                end
            end
            PLAY: begin
                if (tick_s) begin
                    presc_d = 24'd0;
                    if (dur_q <= 8'd1) begin
                        song_d = 32'h0000_0000;
                        if (GAP_TICKS > 0) begin
                            dur_d   = GAP_LEN;
                            state_d = GAP;
                        end else begin
                            adv_s = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + 24'd1;
                end
            end
            GAP: begin
                if (tick_s) begin
                    presc_d = 24'd0;
                    if (dur_q <= 8'd1) begin
                        adv_s = 1'b1;
                    end else begin
                        dur_d = dur_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + 24'd1;
                end
            end
            default: begin
                song_d  = 32'h0000_0000;
                state_d = IDLE;
            end
        endcase

        if (stop_s || (adv_s && adv_stop_s)) begin
            done_d    = 1'b1;
            ctrl_d[0] = 1'b0;
            song_d    = 32'h0000_0000;
            state_d   = IDLE;
        end else if (adv_s) begin
            idx_d   = adv_idx_s;
            state_d = FETCH;
        end else begin
            done_d = 1'b0;
        end

        if (reg_wr_s) begin
            case (avs_address[1:0])
                REG_CTRL: begin
                    ctrl_d[1] = avs_writedata[1];
                    if (state_q == IDLE) begin
                        ctrl_d[0] = avs_writedata[0];
                        if (avs_writedata[0]) begin
                            idx_d   = {IDX_W{1'b0}};
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (!avs_writedata[0]) begin
                        // Host stop: silence next cycle, keep the index, no done pulse.
                        ctrl_d[0] = 1'b0;
                        song_d    = 32'h0000_0000;
                        done_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        ctrl_d[0] = ctrl_d[0];
                    end
                end
                REG_TICK: begin
                    tick_d = avs_writedata[23:0];
                end
                default: begin
                    tick_d = tick_d;
                end
            endcase
        end else begin
            tick_d = tick_d;
        end
    end

    // Register-file read mux, sampled into the read-data register on avs_read.
    always_comb begin
        reg_rd_d = 32'h0000_0000;
        case (avs_address[1:0])
            REG_CTRL:   reg_rd_d = {30'h0000_0000, ctrl_q};
            REG_TICK:   reg_rd_d = {8'h00, tick_q};
            REG_STATUS: begin
                reg_rd_d[31]          = playing_q;
                reg_rd_d[IDX_W-1:0]   = idx_q;
            end
            default:    reg_rd_d = 32'h0000_0000;
        endcase
    end

    // State, register file, counters, outputs and host read-data registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            ctrl_q    <= 2'b00;
            tick_q    <= 24'd0;
            presc_q   <= 24'd0;
            dur_q     <= 8'd0;
            idx_q     <= {IDX_W{1'b0}};
            song_q    <= 32'h0000_0000;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
            reg_rd_q  <= 32'h0000_0000;
            ram_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            tick_q    <= tick_d;
            presc_q   <= presc_d;
            dur_q     <= dur_d;
            idx_q     <= idx_d;
            song_q    <= song_d;
            done_q    <= done_d;
            playing_q <= (state_d != IDLE);
            if (avs_read) begin
                ram_sel_q <= ~avs_address[IDX_W];
                reg_rd_q  <= reg_rd_d;
            end
        end
    end

    assign avs_readdata = ram_sel_q ? ram_a_rdata_s : reg_rd_q;
    assign song         = song_q;
    assign playing      = playing_q;
    assign note_index   = idx_q;
    assign song_done    = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: register/RAM access table plus
// hand-written multi-cycle play, loop, stop, empty-score, wrap and reset cases.
module tb_song_sequencer;

    localparam int DEPTH = 64;
    localparam int IDX_W = 6;
    localparam logic [IDX_W:0] A_CTRL = 7'h40;
    localparam logic [IDX_W:0] A_TICK = 7'h41;
    localparam logic [IDX_W:0] A_STAT = 7'h42;
    localparam logic [IDX_W:0] A_RSVD = 7'h43;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [IDX_W:0]   avs_address;
    logic             avs_write;
    logic             avs_read;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic [31:0]      song;
    logic             playing;
    logic [IDX_W-1:0] note_index;
    logic             song_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [IDX_W:0] addr;
        logic [31:0]    wdata;
        logic [31:0]    exp;
    } vec_t;
    vec_t vecs[9];

    song_sequencer #(.DEPTH(DEPTH), .GAP_TICKS(1)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .song          (song),
        .playing       (playing),
        .note_index    (note_index),
        .song_done     (song_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [IDX_W:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [IDX_W:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        step();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic rw(input logic [IDX_W:0] a, input logic [31:0] wd, output logic [31:0] d);
        avs_address   = a;
        avs_writedata = wd;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        step();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        d             = avs_readdata;
    endtask

    // Expected song word k cycles after a looping start with the two-note score.
    function automatic logic [31:0] exp_loop(input int k);
        int p;
        if (k < 2) return 32'h0;
        p = (k - 2) % 34;
        if (p < 12)      return 32'h0007_1604;
        else if (p < 18) return 32'h0;
        else if (p < 26) return 32'h0004_0000;
        else             return 32'h0;
    endfunction

    initial begin
        logic [31:0] d;
        int first, len, other, done_cnt, done_at, n, last_idx, wrapped, prev_zero, seen_done;

        RESET = 1'b1;
        avs_address = '0;
        avs_write = 1'b0;
        avs_read = 1'b0;
        avs_writedata = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;

        chk("rst_song", song, 32'h0);
        chk("rst_playing", 32'(playing), 32'h0);
        chk("rst_index", 32'(note_index), 32'h0);
        chk("rst_done", 32'(song_done), 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);

        vecs[0] = '{A_STAT, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[1] = '{A_TICK, 32'h0012_3456, 32'h0012_3456};
        vecs[2] = '{A_TICK, 32'hFFAB_CDEF, 32'h00AB_CDEF};
        vecs[3] = '{A_RSVD, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4] = '{A_CTRL, 32'h0000_0002, 32'h0000_0002};
        vecs[5] = '{A_CTRL, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[6] = '{7'd5,   32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7] = '{7'd63,  32'h1234_5678, 32'h1234_5678};
        vecs[8] = '{7'd10,  32'hCAFE_F00D, 32'hCAFE_F00D};
        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // Simultaneous read and write return the pre-write value.
        rw(7'd10, 32'h0BAD_F00D, d);
        chk("rw_ram_old", d, 32'hCAFE_F00D);
        rd(7'd10, d);
        chk("rw_ram_new", d, 32'h0BAD_F00D);
        rw(A_TICK, 32'h0000_0004, d);
        chk("rw_tick_old", d, 32'h00AB_CDEF);

        // Single note: 3 ticks x 4 CLK.
        wr(7'd0, 32'h0307_1604);
        wr(7'd1, 32'h0);
        wr(A_CTRL, 32'h1);
        first = -1; len = 0; other = 0; done_cnt = 0; done_at = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (song == 32'h0007_1604) begin
                if (first < 0) first = k;
                len++;
            end else if (song != 32'h0) begin
                other++;
            end
            if (song_done) begin
                done_cnt++;
                done_at = k;
            end
        end
        chk("single_first", 32'(first), 32'd2);
        chk("single_len", 32'(len), 32'd12);
        chk("single_other", 32'(other), 32'd0);
        chk("single_done_cnt", 32'(done_cnt), 32'd1);
        chk("single_done_at", 32'(done_at), 32'd20);
        chk("single_playing", 32'(playing), 32'h0);
        rd(A_CTRL, d);
        chk("single_ctrl", d, 32'h0);

        // Looping two-note score.
        wr(7'd1, 32'h0204_0000);
        wr(7'd2, 32'h0);
        wr(A_CTRL, 32'h3);
        done_cnt = 0;
        for (int k = 1; k <= 80; k++) begin
            step();
            chk($sformatf("loop_song_k%0d", k), song, exp_loop(k));
            if (song_done) done_cnt++;
        end
        chk("loop_no_done", 32'(done_cnt), 32'd0);
        chk("loop_playing", 32'(playing), 32'h1);
        wr(A_CTRL, 32'h0);
        chk("loop_stop_playing", 32'(playing), 32'h0);

        // Stop mid-note.
        wr(A_CTRL, 32'h1);
        repeat (5) step();
        chk("stop_in_note", song, 32'h0007_1604);
        wr(A_CTRL, 32'h0);
        chk("stop_song", song, 32'h0);
        chk("stop_playing", 32'(playing), 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (song_done || song != 32'h0) done_cnt++;
        end
        chk("stop_quiet", 32'(done_cnt), 32'd0);
        rd(A_STAT, d);
        chk("stop_status", d, 32'h0);

        // Empty score with loop requested.
        wr(7'd0, 32'h0);
        wr(A_CTRL, 32'h3);
        done_at = -1; other = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (song_done && done_at < 0) done_at = k;
            if (song != 32'h0) other++;
        end
        chk("empty_done_at", 32'(done_at), 32'd2);
        chk("empty_song", 32'(other), 32'd0);
        chk("empty_playing", 32'(playing), 32'h0);
        rd(A_CTRL, d);
        chk("empty_ctrl", d, 32'h2);

        // Wrap without loop: every entry one tick long.
        wr(A_CTRL, 32'h0);
        wr(A_TICK, 32'h1);
        for (int i = 0; i < DEPTH; i++) wr(7'(i), 32'h0100_0100 | 32'(i));
        wr(A_CTRL, 32'h1);
        n = 0; prev_zero = 1; seen_done = 0;
        for (int k = 0; k < 400 && seen_done == 0; k++) begin
            step();
            if (song != 32'h0 && prev_zero != 0) begin
                chk("wrap_song", song, 32'h0000_0100 + 32'(n));
                chk("wrap_index", 32'(note_index), 32'(n));
                n++;
            end
            prev_zero = (song == 32'h0) ? 1 : 0;
            if (song_done) seen_done = 1;
        end
        chk("wrap_notes", 32'(n), 32'(DEPTH));
        chk("wrap_done", 32'(seen_done), 32'd1);

        // Wrap with loop: index returns to 0 after DEPTH-1.
        wr(A_CTRL, 32'h3);
        last_idx = 0; wrapped = 0; seen_done = 0;
        for (int k = 0; k < 400 && wrapped == 0; k++) begin
            step();
            if (song_done) seen_done = 1;
            if (32'(note_index) != 32'(last_idx)) begin
                if (last_idx == DEPTH - 1) begin
                    chk("loopwrap_index", 32'(note_index), 32'h0);
                    wrapped = 1;
                end
                last_idx = int'(note_index);
            end
        end
        chk("loopwrap_seen", 32'(wrapped), 32'd1);
        chk("loopwrap_no_done", 32'(seen_done), 32'd0);

        // Reset in the middle of a note.
        wr(A_CTRL, 32'h0);
        wr(7'd0, 32'h05AB_CDEF);
        wr(7'd1, 32'h0);
        wr(A_TICK, 32'h4);
        wr(A_CTRL, 32'h1);
        repeat (6) step();
        chk("rstplay_song_before", song, 32'h00AB_CDEF);
        #2;
        RESET = 1'b1;
        #1;
        chk("rstplay_song", song, 32'h0);
        chk("rstplay_playing", 32'(playing), 32'h0);
        chk("rstplay_index", 32'(note_index), 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rstplay_readdata", avs_readdata, 32'h0);
        rd(A_TICK, d);
        chk("rstplay_tick", d, 32'h0);
        rd(A_CTRL, d);
        chk("rstplay_ctrl", d, 32'h0);
        rd(A_STAT, d);
        chk("rstplay_status", d, 32'h0);
        rd(7'd0, d);
        chk("rstplay_ram0", d, 32'h05AB_CDEF);
        rd(7'd5, d);
        chk("rstplay_ram5", d, 32'h0100_0105);
        rd(7'd63, d);
        chk("rstplay_ram63", d, 32'h0100_013F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
